// File: rtl/ram_tdp_be.sv
// True dual-port RAM with byte enables, one clock.
// Configurable read-during-write mode and output register depth.
module ram_tdp_be #(
  parameter int ADDR_WDT   = 10,
  parameter int BYTE_NUM   = 4,
  parameter int BYTE_WDT   = 8,
  parameter int RD_MODE    = 0,
  parameter int OUT_STAGES = 1
) (
  input  logic                         clka,
  input  logic                         rst,
  input  logic                         ena,
  input  logic [BYTE_NUM-1:0]          wea,
  input  logic [ADDR_WDT-1:0]          addra,
  input  logic [BYTE_NUM*BYTE_WDT-1:0] dina,
  output logic [BYTE_NUM*BYTE_WDT-1:0] douta,
  output logic                         vlda,
  input  logic                         enb,
  input  logic [BYTE_NUM-1:0]          web,
  input  logic [ADDR_WDT-1:0]          addrb,
  input  logic [BYTE_NUM*BYTE_WDT-1:0] dinb,
  output logic [BYTE_NUM*BYTE_WDT-1:0] doutb,
  output logic                         vldb,
  output logic                         coll
);

  localparam int W     = BYTE_NUM * BYTE_WDT;
  localparam int DEPTH = 2 ** ADDR_WDT;

  logic [W-1:0] mem [DEPTH];

  logic                same;
  logic                coll_c;
  logic [BYTE_NUM-1:0] web_eff;
  logic [W-1:0]        olda;
  logic [W-1:0]        oldb;
  logic [W-1:0]        posta;
  logic [W-1:0]        postb;
  logic [W-1:0]        rdata_a;
  logic [W-1:0]        rdata_b;
  logic                rda;
  logic                rdb;

  logic [W-1:0]      da_q [OUT_STAGES+1];
  logic [W-1:0]      db_q [OUT_STAGES+1];
  logic [OUT_STAGES:0] va_q;
  logic [OUT_STAGES:0] vb_q;

  // Port A owns every lane it writes on a shared address
  always_comb begin
    same    = ena && enb && (addra == addrb);
    coll_c  = same && (|wea || |web);
    web_eff = same ? (web & ~wea) : web;
    olda    = mem[addra];
    oldb    = mem[addrb];
    posta   = olda;
    postb   = oldb;
    for (int i = 0; i < BYTE_NUM; i++) begin
      if (wea[i])
        posta[i*BYTE_WDT +: BYTE_WDT] = dina[i*BYTE_WDT +: BYTE_WDT];
      else if (same && web_eff[i])
        posta[i*BYTE_WDT +: BYTE_WDT] = dinb[i*BYTE_WDT +: BYTE_WDT];
      if (web_eff[i])
        postb[i*BYTE_WDT +: BYTE_WDT] = dinb[i*BYTE_WDT +: BYTE_WDT];
      else if (same && wea[i])
        postb[i*BYTE_WDT +: BYTE_WDT] = dina[i*BYTE_WDT +: BYTE_WDT];
    end
    rda     = ena && !(RD_MODE == 2 && |wea);
    rdb     = enb && !(RD_MODE == 2 && |web);
    rdata_a = (RD_MODE == 1 && |wea) ? posta : olda;
    rdata_b = (RD_MODE == 1 && |web) ? postb : oldb;
  end

  always_ff @(posedge clka) begin
    if (!rst) begin
      for (int i = 0; i < BYTE_NUM; i++) begin
        if (ena && wea[i])
          mem[addra][i*BYTE_WDT +: BYTE_WDT] <= dina[i*BYTE_WDT +: BYTE_WDT];
        if (enb && web_eff[i])
          mem[addrb][i*BYTE_WDT +: BYTE_WDT] <= dinb[i*BYTE_WDT +: BYTE_WDT];
      end
    end
  end

  // Data registers load only with a valid beat so outputs hold between reads
  always_ff @(posedge clka) begin
    if (rst) begin
      va_q <= '0;
      vb_q <= '0;
      coll <= 1'b0;
      for (int k = 0; k <= OUT_STAGES; k++) begin
        da_q[k] <= '0;
        db_q[k] <= '0;
      end
    end else begin
      va_q[0] <= rda;
      vb_q[0] <= rdb;
      if (rda) da_q[0] <= rdata_a;
      if (rdb) db_q[0] <= rdata_b;
      for (int k = 1; k <= OUT_STAGES; k++) begin
        va_q[k] <= va_q[k-1];
        vb_q[k] <= vb_q[k-1];
        if (va_q[k-1]) da_q[k] <= da_q[k-1];
        if (vb_q[k-1]) db_q[k] <= db_q[k-1];
      end
      coll <= coll_c;
    end
  end

  assign douta = da_q[OUT_STAGES];
  assign doutb = db_q[OUT_STAGES];
  assign vlda  = va_q[OUT_STAGES];
  assign vldb  = vb_q[OUT_STAGES];

endmodule

// File: tb/tb_ram_tdp_be.sv
// Bench for ram_tdp_be: all RD_MODE x OUT_STAGES variants
// share one stimulus stream; instance k has mode k/3, stages k%3.
module tb_ram_tdp_be;

  localparam int NI = 9;
  localparam int NR = 10000;

  logic        clka;
  logic        rst;
  logic        ena;
  logic [3:0]  wea;
  logic [9:0]  addra;
  logic [31:0] dina;
  logic        enb;
  logic [3:0]  web;
  logic [9:0]  addrb;
  logic [31:0] dinb;

  logic [31:0] douta_w [NI];
  logic [31:0] doutb_w [NI];
  logic        vlda_w  [NI];
  logic        vldb_w  [NI];
  logic        coll_w  [NI];

  int total;
  int bad;

  logic [31:0] mm [8];
  logic        ev_va [3][NR];
  logic        ev_vb [3][NR];
  logic [31:0] ev_da [3][NR];
  logic [31:0] ev_db [3][NR];
  logic        ev_c  [NR];
  logic [31:0] ha  [NI];
  logic [31:0] hb  [NI];
  bit          hva [NI];
  bit          hvb [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ram_tdp_be #(
      .RD_MODE    (g / 3),
      .OUT_STAGES (g % 3)
    ) u_dut (
      .clka  (clka),
      .rst   (rst),
      .ena   (ena),
      .wea   (wea),
      .addra (addra),
      .dina  (dina),
      .douta (douta_w[g]),
      .vlda  (vlda_w[g]),
      .enb   (enb),
      .web   (web),
      .addrb (addrb),
      .dinb  (dinb),
      .doutb (doutb_w[g]),
      .vldb  (vldb_w[g]),
      .coll  (coll_w[g])
    );
  end

  initial clka = 1'b0;
  always #5 clka = ~clka;

  initial begin
    #5_000_000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0;
    enb = 1'b0;
    wea = 4'h0;
    web = 4'h0;
  endtask

  task automatic wr_a(input logic [9:0] a,
                      input logic [31:0] d,
                      input logic [3:0] we);
    ena   = 1'b1;
    wea   = we;
    addra = a;
    dina  = d;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    for (int k = 0; k < NI; k++) begin
      total++;
      if (douta_w[k] !== 32'h0 || vlda_w[k] !== 1'b0 ||
          doutb_w[k] !== 32'h0 || vldb_w[k] !== 1'b0 ||
          coll_w[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset k=%0d douta=%h vlda=%b doutb=%h vldb=%b coll=%b want all 0",
                 k, douta_w[k], vlda_w[k], doutb_w[k], vldb_w[k], coll_w[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    wr_a(10'h005, 32'hDEADBEEF, 4'hF);
    repeat (3) step();
    ena   = 1'b1;
    addra = 10'h005;
    step();
    idle();
    total++;
    if (vlda_w[0] !== 1'b1 || douta_w[0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic_os0 got v=%b d=%h want 1 deadbeef", vlda_w[0], douta_w[0]);
    end
    total++;
    if (vlda_w[1] !== 1'b0) begin
      bad++;
      $display("FAIL basic_early got vlda=%b want 0", vlda_w[1]);
    end
    step();
    total++;
    if (vlda_w[1] !== 1'b1 || douta_w[1] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic_os1 got v=%b d=%h want 1 deadbeef", vlda_w[1], douta_w[1]);
    end
    total++;
    if (vlda_w[0] !== 1'b0 || douta_w[0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic_hold0 got v=%b d=%h want 0 deadbeef", vlda_w[0], douta_w[0]);
    end
    step();
    total++;
    if (vlda_w[1] !== 1'b0 || douta_w[1] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic_hold1 got v=%b d=%h want 0 deadbeef", vlda_w[1], douta_w[1]);
    end
    total++;
    if (vlda_w[2] !== 1'b1 || douta_w[2] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic_os2 got v=%b d=%h want 1 deadbeef", vlda_w[2], douta_w[2]);
    end
    repeat (2) step();
  endtask

  task automatic test_byte_lanes();
    wr_a(10'h010, 32'h11223344, 4'hF);
    repeat (3) step();
    enb   = 1'b1;
    addrb = 10'h010;
    web   = 4'h5;
    dinb  = 32'hAABBCCDD;
    step();
    idle();
    step();
    total++;
    if (vldb_w[1] !== 1'b1 || doutb_w[1] !== 32'h11223344) begin
      bad++;
      $display("FAIL lanes_rdfirst got v=%b d=%h want 1 11223344", vldb_w[1], doutb_w[1]);
    end
    total++;
    if (vldb_w[4] !== 1'b1 || doutb_w[4] !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL lanes_wrfirst got v=%b d=%h want 1 11bb33dd", vldb_w[4], doutb_w[4]);
    end
    repeat (2) step();
    ena   = 1'b1;
    addra = 10'h010;
    enb   = 1'b1;
    addrb = 10'h010;
    step();
    idle();
    total++;
    if (coll_w[1] !== 1'b0) begin
      bad++;
      $display("FAIL lanes_rdrd_coll got %b want 0", coll_w[1]);
    end
    step();
    total++;
    if (vlda_w[1] !== 1'b1 || douta_w[1] !== 32'h11BB33DD ||
        vldb_w[1] !== 1'b1 || doutb_w[1] !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL lanes_read got a=%b/%h b=%b/%h want 1/11bb33dd both",
               vlda_w[1], douta_w[1], vldb_w[1], doutb_w[1]);
    end
    repeat (2) step();
  endtask

  task automatic test_collision();
    wr_a(10'h020, 32'h0, 4'hF);
    repeat (3) step();
    ena   = 1'b1;
    addra = 10'h020;
    wea   = 4'h3;
    dina  = 32'h000000FF;
    enb   = 1'b1;
    addrb = 10'h020;
    web   = 4'hF;
    dinb  = 32'h12345678;
    step();
    idle();
    for (int k = 0; k < NI; k++) begin
      total++;
      if (coll_w[k] !== 1'b1) begin
        bad++;
        $display("FAIL coll_pulse k=%0d got %b want 1", k, coll_w[k]);
      end
    end
    step();
    for (int k = 0; k < NI; k++) begin
      total++;
      if (coll_w[k] !== 1'b0) begin
        bad++;
        $display("FAIL coll_end k=%0d got %b want 0", k, coll_w[k]);
      end
    end
    repeat (2) step();
    ena   = 1'b1;
    addra = 10'h020;
    step();
    idle();
    step();
    total++;
    if (vlda_w[1] !== 1'b1 || douta_w[1] !== 32'h123400FF) begin
      bad++;
      $display("FAIL coll_merge got v=%b d=%h want 1 123400ff", vlda_w[1], douta_w[1]);
    end
    repeat (2) step();
    ena   = 1'b1;
    addra = 10'h020;
    wea   = 4'hF;
    dina  = 32'hCAFEF00D;
    enb   = 1'b1;
    addrb = 10'h020;
    step();
    idle();
    total++;
    if (coll_w[1] !== 1'b1) begin
      bad++;
      $display("FAIL coll_wr_rd got %b want 1", coll_w[1]);
    end
    step();
    total++;
    if (doutb_w[1] !== 32'h123400FF || doutb_w[4] !== 32'h123400FF ||
        doutb_w[7] !== 32'h123400FF) begin
      bad++;
      $display("FAIL coll_xread got m0=%h m1=%h m2=%h want 123400ff",
               doutb_w[1], doutb_w[4], doutb_w[7]);
    end
    total++;
    if (douta_w[1] !== 32'h123400FF || douta_w[4] !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL coll_own got m0=%h m1=%h want 123400ff cafef00d",
               douta_w[1], douta_w[4]);
    end
    repeat (2) step();
  endtask

  task automatic test_rdw();
    wr_a(10'h030, 32'h1, 4'hF);
    repeat (3) step();
    ena   = 1'b1;
    addra = 10'h030;
    step();
    idle();
    repeat (3) step();
    wr_a(10'h030, 32'h2, 4'hF);
    step();
    total++;
    if (vlda_w[1] !== 1'b1 || douta_w[1] !== 32'h1) begin
      bad++;
      $display("FAIL rdw_m0 got v=%b d=%h want 1 1", vlda_w[1], douta_w[1]);
    end
    total++;
    if (vlda_w[4] !== 1'b1 || douta_w[4] !== 32'h2) begin
      bad++;
      $display("FAIL rdw_m1 got v=%b d=%h want 1 2", vlda_w[4], douta_w[4]);
    end
    total++;
    if (vlda_w[7] !== 1'b0 || douta_w[7] !== 32'h1) begin
      bad++;
      $display("FAIL rdw_m2 got v=%b d=%h want 0 1", vlda_w[7], douta_w[7]);
    end
    step();
    total++;
    if (vlda_w[8] !== 1'b0 || douta_w[8] !== 32'h1) begin
      bad++;
      $display("FAIL rdw_m2_os2 got v=%b d=%h want 0 1", vlda_w[8], douta_w[8]);
    end
    repeat (2) step();
  endtask

  task automatic test_reset_flush();
    wr_a(10'h040, 32'hA0A0A0A0, 4'hF);
    wr_a(10'h041, 32'hA1A1A1A1, 4'hF);
    wr_a(10'h042, 32'hA2A2A2A2, 4'hF);
    repeat (3) step();
    ena = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addra = 10'h040 + 10'(i);
      step();
    end
    rst   = 1'b1;
    addra = 10'h040;
    wea   = 4'hF;
    dina  = 32'hBADBAD00;
    step();
    rst = 1'b0;
    idle();
    total++;
    if (vlda_w[2] !== 1'b0 || douta_w[2] !== 32'h0) begin
      bad++;
      $display("FAIL flush_rst got v=%b d=%h want 0 0", vlda_w[2], douta_w[2]);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (vlda_w[2] !== 1'b0 || douta_w[2] !== 32'h0) begin
        bad++;
        $display("FAIL flush_after%0d got v=%b d=%h want 0 0", i, vlda_w[2], douta_w[2]);
      end
    end
    ena   = 1'b1;
    addra = 10'h040;
    step();
    idle();
    total++;
    if (vlda_w[1] !== 1'b0) begin
      bad++;
      $display("FAIL post_rst_early got %b want 0", vlda_w[1]);
    end
    step();
    total++;
    if (vlda_w[1] !== 1'b1 || douta_w[1] !== 32'hA0A0A0A0) begin
      bad++;
      $display("FAIL post_rst_os1 got v=%b d=%h want 1 a0a0a0a0", vlda_w[1], douta_w[1]);
    end
    step();
    total++;
    if (vlda_w[2] !== 1'b1 || douta_w[2] !== 32'hA0A0A0A0) begin
      bad++;
      $display("FAIL post_rst_os2 got v=%b d=%h want 1 a0a0a0a0", vlda_w[2], douta_w[2]);
    end
    repeat (2) step();
  endtask

  task automatic test_random();
    logic [31:0] olda, oldb, posta, postb;
    logic        ev;
    int          m, s;
    for (int a = 0; a < 8; a++) begin
      mm[a] = $urandom;
      wr_a(10'(a), mm[a], 4'hF);
    end
    repeat (4) step();
    for (int k = 0; k < NI; k++) begin
      hva[k] = 1'b0;
      hvb[k] = 1'b0;
    end
    for (int t = 0; t < NR; t++) begin
      ena   = ($urandom_range(0, 3) != 0);
      enb   = ($urandom_range(0, 3) != 0);
      addra = 10'($urandom_range(0, 7));
      addrb = 10'($urandom_range(0, 7));
      wea   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      web   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      dina  = $urandom;
      dinb  = $urandom;
      olda  = mm[addra[2:0]];
      oldb  = mm[addrb[2:0]];
      if (enb)
        for (int i = 0; i < 4; i++)
          if (web[i]) mm[addrb[2:0]][i*8 +: 8] = dinb[i*8 +: 8];
      if (ena)
        for (int i = 0; i < 4; i++)
          if (wea[i]) mm[addra[2:0]][i*8 +: 8] = dina[i*8 +: 8];
      posta = mm[addra[2:0]];
      postb = mm[addrb[2:0]];
      for (int md = 0; md < 3; md++) begin
        ev_va[md][t] = ena && !(md == 2 && wea != 0);
        ev_vb[md][t] = enb && !(md == 2 && web != 0);
        ev_da[md][t] = (md == 1 && wea != 0) ? posta : olda;
        ev_db[md][t] = (md == 1 && web != 0) ? postb : oldb;
      end
      ev_c[t] = ena && enb && (addra == addrb) && (wea != 0 || web != 0);
      step();
      for (int k = 0; k < NI; k++) begin
        m = k / 3;
        s = t - (k % 3);
        ev = (s >= 0) ? ev_va[m][s] : 1'b0;
        if (ev) begin
          ha[k]  = ev_da[m][s];
          hva[k] = 1'b1;
        end
        total++;
        if (vlda_w[k] !== ev || (hva[k] && douta_w[k] !== ha[k])) begin
          bad++;
          $display("FAIL rnd_a t=%0d k=%0d got v=%b d=%h want v=%b d=%h",
                   t, k, vlda_w[k], douta_w[k], ev, ha[k]);
        end
        ev = (s >= 0) ? ev_vb[m][s] : 1'b0;
        if (ev) begin
          hb[k]  = ev_db[m][s];
          hvb[k] = 1'b1;
        end
        total++;
        if (vldb_w[k] !== ev || (hvb[k] && doutb_w[k] !== hb[k])) begin
          bad++;
          $display("FAIL rnd_b t=%0d k=%0d got v=%b d=%h want v=%b d=%h",
                   t, k, vldb_w[k], doutb_w[k], ev, hb[k]);
        end
        total++;
        if (coll_w[k] !== ev_c[t]) begin
          bad++;
          $display("FAIL rnd_coll t=%0d k=%0d got %b want %b", t, k, coll_w[k], ev_c[t]);
        end
      end
    end
    idle();
    repeat (3) step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    addra = '0;
    addrb = '0;
    dina  = '0;
    dinb  = '0;
    idle();
    test_reset();
    test_basic();
    test_byte_lanes();
    test_collision();
    test_rdw();
    test_reset_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
